sobel_window: RTL and testbench



---
 rtl/sobel_window.sv | 112 +++++++++++
 tb/tb_sobel_window.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_window.sv
// Raster-scan 3x3 window generator feeding the sobel stage.
// Two line buffers hold the previous two image lines. A 3x3 shift register
// presents the eight neighbour taps, zero-extended by one bit. win_valid is
// raised only for windows that lie completely inside the image.
module sobel_window #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W:0]   p0,
  output logic [PIX_W:0]   p1,
  output logic [PIX_W:0]   p2,
  output logic [PIX_W:0]   p3,
  output logic [PIX_W:0]   p5,
  output logic [PIX_W:0]   p6,
  output logic [PIX_W:0]   p7,
  output logic [PIX_W:0]   p8,
  output logic             win_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;

  // lb0 holds the previous line, lb1 the line before that; neither is reset
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] top_new;
  logic [PIX_W-1:0] mid_new;

  // Window rows: t = top, m = middle, b = bottom; index 0 is the left column
  logic [PIX_W-1:0] t0, t1, t2;
  logic [PIX_W-1:0] m0, m1, m2;
  logic [PIX_W-1:0] b0, b1, b2;

  // sof forces the accepted pixel to (0,0) regardless of the running counters
  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;
  assign top_new = lb1[cur_col];
  assign mid_new = lb0[cur_col];

  // Coordinate counters plus the per-accept win_valid and frame_done flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        win_valid <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        if (cur_col == COL_LAST) begin
          col <= '0;
          if (cur_row == ROW_LAST) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= cur_row + RW'(1);
          end
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
    end
  end

  // Window shift register: shift left, load the new right column on accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t0 <= '0; t1 <= '0; t2 <= '0;
      m0 <= '0; m1 <= '0; m2 <= '0;
      b0 <= '0; b1 <= '0; b2 <= '0;
    end else if (pix_valid) begin
      t0 <= t1; t1 <= t2; t2 <= top_new;
      m0 <= m1; m1 <= m2; m2 <= mid_new;
      b0 <= b1; b1 <= b2; b2 <= pix_in;
    end
  end

  // Line buffers: read-before-write at the current column pushes lines down
  always_ff @(posedge clk) begin
    if (pix_valid && rst_n) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= pix_in;
    end
  end

  assign p0 = {1'b0, t0};
  assign p1 = {1'b0, t1};
  assign p2 = {1'b0, t2};
  assign p3 = {1'b0, m0};
  assign p5 = {1'b0, m2};
  assign p6 = {1'b0, b0};
  assign p7 = {1'b0, b1};
  assign p8 = {1'b0, b2};

endmodule

// File: tb/tb_sobel_window.sv
// Testbench for sobel_window on a 4x4 image with pixel value 16*row+col.
module tb_sobel_window;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [8:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic       win_valid;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pv;
    logic        sof;
    logic [7:0]  pix;
    logic        exp_wv;
    logic        exp_fd;
    logic        chk_taps;
    logic [71:0] exp_taps;
  } vec_t;

  vec_t        vecs[$];
  logic        last_wv;
  logic [71:0] last_taps;

  sobel_window #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [8:0] tapv(input int r, input int c, input bit ff);
    return ff ? 9'h0FF : {1'b0, 8'(16 * r + c)};
  endfunction

  // One accepted pixel at (r,c); the window it completes is rows r-2..r, cols c-2..c
  function automatic void pushPixel(input int r, input int c, input bit s, input bit ff);
    vec_t v;
    v.pv       = 1'b1;
    v.sof      = s;
    v.pix      = ff ? 8'hFF : 8'(16 * r + c);
    v.exp_wv   = (r >= 2) && (c >= 2);
    v.exp_fd   = (r == H - 1) && (c == W - 1);
    v.chk_taps = v.exp_wv;
    v.exp_taps = '0;
    if (v.exp_wv)
      v.exp_taps = {tapv(r-2, c-2, ff), tapv(r-2, c-1, ff), tapv(r-2, c, ff),
                    tapv(r-1, c-2, ff), tapv(r-1, c, ff),
                    tapv(r, c-2, ff), tapv(r, c-1, ff), tapv(r, c, ff)};
    last_wv   = v.exp_wv;
    last_taps = v.exp_taps;
    vecs.push_back(v);
  endfunction

  // Idle cycles: taps hold, win_valid low, stray sof ignored
  function automatic void pushGap(input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.pv       = 1'b0;
      v.sof      = 1'($urandom_range(0, 1));
      v.pix      = 8'($urandom);
      v.exp_wv   = 1'b0;
      v.exp_fd   = 1'b0;
      v.chk_taps = last_wv;
      v.exp_taps = last_taps;
      vecs.push_back(v);
    end
  endfunction

  function automatic void addFrame(input bit sof_first, input bit gaps, input bit ff);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pushPixel(r, c, sof_first && r == 0 && c == 0, ff);
        if (gaps) pushGap($urandom_range(1, 5));
      end
  endfunction

  task automatic cmp(input string name, input int idx, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s vec %0d got %h expected %h", name, idx, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pix_valid = v.pv;
    sof       = v.sof;
    pix_in    = v.pix;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string       names[8] = '{"p0", "p1", "p2", "p3", "p5", "p6", "p7", "p8"};
    logic [71:0] got;
    got = {p0, p1, p2, p3, p5, p6, p7, p8};
    cmp("win_valid", idx, {8'd0, win_valid}, {8'd0, v.exp_wv});
    cmp("frame_done", idx, {8'd0, frame_done}, {8'd0, v.exp_fd});
    if (v.chk_taps)
      for (int i = 0; i < 8; i++)
        cmp(names[i], idx, got[71-9*i -: 9], v.exp_taps[71-9*i -: 9]);
  endtask

  task automatic checkCleared(input string tag);
    logic [71:0] got;
    got = {p0, p1, p2, p3, p5, p6, p7, p8};
    cmp({tag, "_taps_msb"}, 0, {8'd0, |got}, 9'd0);
    for (int i = 0; i < 8; i++) cmp({tag, "_tap"}, i, got[71-9*i -: 9], 9'd0);
    cmp({tag, "_win_valid"}, 0, {8'd0, win_valid}, 9'd0);
    cmp({tag, "_frame_done"}, 0, {8'd0, frame_done}, 9'd0);
  endtask

  // Apply the queued vectors one per clock and verify the window count
  task automatic runVectors(input string tag, input int exp_windows);
    int seen = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i], i);
      if (win_valid === 1'b1) seen++;
    end
    cmp({tag, "_window_count"}, 0, 9'(seen), 9'(exp_windows));
    vecs.delete();
  endtask

  initial begin
    last_wv   = 1'b0;
    last_taps = '0;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkCleared("reset");
    rst_n = 1'b1;

    // Continuous frame, back-to-back frame without sof, gapped frame,
    // all-0xFF frame, then a normal frame to show the 0xFF data flushes out
    addFrame(1, 0, 0);
    addFrame(0, 0, 0);
    addFrame(1, 1, 0);
    addFrame(1, 0, 1);
    addFrame(1, 0, 0);
    runVectors("main", 5 * (H - 2) * (W - 2));

    // sof on the 7th pixel: the restarted frame produces its windows from
    // the 11th pixel on, built only from new-frame data
    for (int k = 0; k < 6; k++) pushPixel(k / W, k % W, k == 0, 0);
    addFrame(1, 0, 0);
    runVectors("midsof", (H - 2) * (W - 2));

    // One-cycle reset after the 9th pixel, with a pixel offered during reset
    for (int k = 0; k < 9; k++) pushPixel(k / W, k % W, k == 0, 0);
    runVectors("prereset", 0);
    rst_n     = 1'b0;
    pix_valid = 1'b1;
    sof       = 1'b0;
    pix_in    = 8'hA5;
    @(posedge clk);
    #1;
    checkCleared("midreset");
    rst_n = 1'b1;
    // No sof on restart: the counters alone must start again at (0,0)
    addFrame(0, 0, 0);
    runVectors("postreset", (H - 2) * (W - 2));

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
